wb_ram: RTL
===========

WB_RAM -- requirements
Module: wb_ram

Interface
REQ-001 Parameter DATA_W, default 32, data bus width in bits; SHALL be a multiple of 8 (lanes NB = DATA_W/8).
REQ-002 Parameter DEPTH, default 1024, memory depth in DATA_W words; SHALL be a power of two.
REQ-003 Parameter ADDR_W, default 32, Wishbone byte-address width.
REQ-004 Parameter BASE_ADDR, default 32'h0000_0000, byte base address of the RAM window; SHALL be aligned to DEPTH*NB.
REQ-005 Parameter READ_LAT, default 1, cycles from accepted read to ack; legal values 1 or 2.
REQ-006 Port i_clk  input  1  sole clock; all state changes on rising edge.
REQ-007 Port i_rst  input  1  reset; synchronous and active-high.
REQ-008 Port i_wb_cyc  input  1  bus cycle valid.
REQ-009 Port i_wb_stb  input  1  transfer strobe.
REQ-010 Port i_wb_we  input  1  1 = write, 0 = read.
REQ-011 Port i_wb_addr  input  ADDR_W  byte address.
REQ-012 Port i_wb_sel  input  NB  byte-lane enables, bit n = bits [8n+7:8n].
REQ-013 Port i_wb_data  input  DATA_W  write data.
REQ-014 Port o_wb_data  output  DATA_W  read data, valid only while o_wb_ack=1.
REQ-015 Port o_wb_ack  output  1  transfer completed successfully.
REQ-016 Port o_wb_err  output  1  transfer terminated with error (address outside window).

Function
REQ-017 Request SHALL be accepted in a cycle where state=IDLE and i_wb_cyc & i_wb_stb = 1.
REQ-018 Word index SHALL be (i_wb_addr - BASE_ADDR) >> log2(NB); address bits below log2(NB) SHALL be ignored.
REQ-019 Address in range iff BASE_ADDR <= i_wb_addr < BASE_ADDR + DEPTH*NB.
REQ-020 FSM states IDLE, WAIT, RESP; IDLE->RESP on accept when write, error, or READ_LAT=1; IDLE->WAIT on in-range read with READ_LAT=2; WAIT->RESP unconditionally; RESP->IDLE unconditionally.
REQ-021 In RESP, exactly one of o_wb_ack / o_wb_err SHALL be 1 for exactly one cycle; both SHALL be 0 in all other states.
REQ-022 In-range write: every lane with i_wb_sel[n]=1 SHALL be written at the accept edge; lanes with sel=0 SHALL be unchanged; any sel pattern, including 0 (no change, still acked), is legal.
REQ-023 In-range read: memory word SHALL be sampled at the accept edge (READ_LAT=1) or registered through one extra stage (READ_LAT=2); o_wb_data lanes with sel=1 SHALL carry memory data, lanes with sel=0 SHALL be 0.
REQ-024 Out-of-range access SHALL not modify memory and SHALL answer o_wb_err=1, o_wb_data=0, after 1 cycle regardless of READ_LAT.
REQ-025 o_wb_data SHALL be 0 whenever o_wb_ack=0.
REQ-026 Address, we, sel of an accepted request SHALL be latched; changes on the bus after accept SHALL not affect the response.
REQ-027 Abort: if i_wb_cyc=0 while in WAIT, FSM SHALL go to IDLE with no ack/err; a write already performed at accept SHALL stand.
REQ-028 Minimum throughput SHALL be one transfer per 2 cycles (READ_LAT=1 / writes) and per 3 cycles (READ_LAT=2 reads); requests presented in RESP SHALL not be accepted until IDLE.
REQ-029 Read of a word written in the immediately preceding transfer SHALL return the new data.
REQ-030 Memory SHALL be byte-lane arrays of DEPTH entries each, inferable as block RAM.

Reset
REQ-031 While i_rst=1 at a rising edge: state<=IDLE, o_wb_ack<=0, o_wb_err<=0, o_wb_data<=0, latched request cleared; no request accepted that cycle.
REQ-032 Reset mid-transfer (WAIT or RESP) SHALL drop the pending response; memory contents SHALL NOT be cleared by reset.

Verification
REQ-033 Full write addr BASE+0x10, sel=1111, data 0xDEADBEEF; read sel=1111 -> ack 1 cycle after accept (READ_LAT=1), data 0xDEADBEEF.
REQ-034 Lane merge: word 0x11223344 at BASE+0x20, write sel=0101 data 0xAABBCCDD; read sel=1111 -> 0x11BB33DD; read sel=0011 -> 0x000033DD.
REQ-035 READ_LAT=2 instance: read accepted cycle N -> ack at N+2 only, ack width 1; back-to-back reads held stb -> accepts at N, N+3.
REQ-036 Access at BASE+DEPTH*NB (write 0xFFFFFFFF) -> err 1 cycle after accept, ack 0; subsequent read of BASE+0 returns prior content.
REQ-037 READ_LAT=2 read, drop i_wb_cyc in WAIT -> no ack/err; next request accepted normally.
REQ-038 Assert i_rst for 1 cycle in RESP -> ack 0 next cycle, o_wb_data 0; previously written data still readable after reset.

Source files
------------

// File: rtl/wb_ram_if.sv
// Wishbone classic slave bus bundle for wb_ram: request from master, response from slave.
interface wb_ram_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned NB = DATA_W / 8;

    logic              i_wb_cyc;
    logic              i_wb_stb;
    logic              i_wb_we;
    logic [ADDR_W-1:0] i_wb_addr;
    logic [NB-1:0]     i_wb_sel;
    logic [DATA_W-1:0] i_wb_data;
    logic [DATA_W-1:0] o_wb_data;
    logic              o_wb_ack;
    logic              o_wb_err;

    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_sel, i_wb_data,
        input  o_wb_data, o_wb_ack, o_wb_err
    );

    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_sel, i_wb_data,
        output o_wb_data, o_wb_ack, o_wb_err
    );
endinterface

// File: rtl/wb_ram.sv
// Wishbone classic single-port RAM with byte lanes, address window decode and 1- or 2-cycle read latency.
// Out-of-window accesses are answered with a one-cycle error and never touch memory.
module wb_ram #(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       DEPTH     = 1024,
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       READ_LAT  = 1
) (
    input logic     i_clk,
    input logic     i_rst,
    wb_ram_if.slave wb
);
    localparam int unsigned NB   = DATA_W / 8;
    localparam int unsigned OFF  = $clog2(NB);
    localparam int unsigned IDXW = $clog2(DEPTH);
    localparam int unsigned AXW  = ADDR_W + 1;
    localparam int unsigned SPAN = DEPTH * NB;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e         state_q;
    logic           ack_q;
    logic           err_q;
    logic [NB-1:0]  sel_q;

    logic [AXW-1:0]    addr_x_c;
    logic [AXW-1:0]    base_x_c;
    logic [AXW-1:0]    offset_c;
    logic              in_range_c;
    logic [IDXW-1:0]   idx_c;
    logic              wr_en_c;
    logic              rd_en_c;
    logic              fire_c;
    logic [NB-1:0]     lane_sel_c;
    logic [DATA_W-1:0] rdata_c;

    // Window decode; one extra bit keeps BASE+span from wrapping at the top of the address space.
    assign addr_x_c   = AXW'(wb.i_wb_addr);
    assign base_x_c   = AXW'(BASE_ADDR);
    assign offset_c   = addr_x_c - base_x_c;
    assign in_range_c = (addr_x_c >= base_x_c) && (offset_c < AXW'(SPAN));
    assign idx_c      = offset_c[OFF +: IDXW];

    always_comb begin
        wr_en_c    = 1'b0;
        rd_en_c    = 1'b0;
        fire_c     = 1'b0;
        lane_sel_c = wb.i_wb_sel;
        if (!i_rst && state_q == S_IDLE && wb.i_wb_cyc && wb.i_wb_stb && in_range_c) begin
            wr_en_c = wb.i_wb_we;
            rd_en_c = !wb.i_wb_we;
        end
        if (state_q == S_WAIT) begin
            lane_sel_c = sel_q;
            fire_c     = !i_rst && wb.i_wb_cyc;
        end
    end

    // Transfer sequencing with registered ack/err.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            sel_q   <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (wb.i_wb_cyc && wb.i_wb_stb) begin
                        sel_q <= wb.i_wb_sel;
                        if (!in_range_c) begin
                            state_q <= S_RESP;
                            err_q   <= 1'b1;
                        end else if (wb.i_wb_we || READ_LAT == 1) begin
                            state_q <= S_RESP;
                            ack_q   <= 1'b1;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!wb.i_wb_cyc) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_RESP;
                        ack_q   <= 1'b1;
                    end
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // One RAM per byte lane; output lanes not selected (or not acking) are forced to zero.
    for (genvar n = 0; n < NB; n++) begin : g_lane
        logic [7:0] mem_q [DEPTH];
        logic [7:0] out_q;

        if (READ_LAT == 1) begin : g_lat1
            always_ff @(posedge i_clk) begin
                if (wr_en_c && wb.i_wb_sel[n]) begin
                    mem_q[idx_c] <= wb.i_wb_data[8*n +: 8];
                end
                if (i_rst) begin
                    out_q <= '0;
                end else if (rd_en_c && lane_sel_c[n]) begin
                    out_q <= mem_q[idx_c];
                end else begin
                    out_q <= '0;
                end
            end
        end else begin : g_lat2
            logic [7:0] rd_q;

            always_ff @(posedge i_clk) begin
                if (wr_en_c && wb.i_wb_sel[n]) begin
                    mem_q[idx_c] <= wb.i_wb_data[8*n +: 8];
                end
                if (rd_en_c) begin
                    rd_q <= mem_q[idx_c];
                end
            end

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    out_q <= '0;
                end else if (fire_c && lane_sel_c[n]) begin
                    out_q <= rd_q;
                end else begin
                    out_q <= '0;
                end
            end
        end

        assign rdata_c[8*n +: 8] = out_q;
    end

    assign wb.o_wb_data = rdata_c;
    assign wb.o_wb_ack  = ack_q;
    assign wb.o_wb_err  = err_q;
endmodule
